encoding_block: RTL
===================

# encoding_block

Transmit-side block encoder for the USB4 logical layer. It collects one byte per lane per `enc_clk` from the lane-adaptation stage and packs them into 132-bit encoded blocks for the serializer: 64b/66b at Gen2, 128b/132b at Gen3, and a 16-byte headerless block at Gen4. It is the transmit counterpart of the lane decoder and uses the same block bit layout, so an encoded block can be decoded back to identical bytes.

## Interface
- `GEN4`, default 0: `gen_speed` code for Gen4.
- `GEN3`, default 1: `gen_speed` code for Gen3.
- `GEN2`, default 2: `gen_speed` code for Gen2.
- `enc_clk`  in  1  byte clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable_enc`  in  1  1 = accept bytes; 0 = abort and idle.
- `gen_speed`  in  2  speed select; code 3 is reserved.
- `data_os`  in  1  block type of current byte: 1 = transport data, 0 = ordered set.
- `lane_0_tx`  in  8  lane 0 byte.
- `lane_1_tx`  in  8  lane 1 byte.
- `lane_0_tx_enc`  out  132  lane 0 encoded block.
- `lane_1_tx_enc`  out  132  lane 1 encoded block.
- `enc_valid`  out  1  one-cycle pulse when a new block is on the outputs.
- `os_err`  out  1  one-cycle pulse when `data_os` changed mid-block.

## Operation
- **Block length N:**
  - Gen2: N = 8.
  - Gen3 and Gen4: N = 16.
  - Reserved code: no capture, counter held at 0.
- **Byte counter** `byte_idx` (4 bits):
  - Counts 0..N-1 on every cycle with `enable_enc`=1, then wraps to 0.
  - The byte on `lane_x_tx` is written into `buf_x[byte_idx]`.
- **Latched at byte 0:** `gen_speed` goes into `gen_q` and `data_os` goes into `type_q`. Both hold for the whole block. A `gen_speed` change mid-block takes effect at the next block.
- **Type check:** if `data_os` differs from `type_q` at byte 1..N-1, pulse `os_err`. The block still uses `type_q`.
- **Block completion:** when the byte at index N-1 is captured, load the output registers and pulse `enc_valid`.
- **Bit layout:**
  - Byte i sits at bits [i*8+7:i*8].
  - Gen3: header at [131:128] = 4'b0101 for data, 4'b1010 for ordered set.
  - Gen2: header at [65:64] = 2'b01 for data, 2'b10 for ordered set; bits [131:66] = 0.
  - Gen4: header bits [131:128] = 0.
- Both lanes are encoded in lockstep with the same header.
- **enable_enc = 0:**
  - Any partial block is discarded and `byte_idx` goes to 0.
  - The output registers hold their last block; `enc_valid` and `os_err` are 0.
- **Reset:** `lane_0_tx_enc`, `lane_1_tx_enc` = 0; `enc_valid` = 0; `os_err` = 0; `byte_idx` = 0; `buf_x` = 0; `gen_q` = 0; `type_q` = 0.

## Timing
- One byte per lane is sampled on each rising `enc_clk` edge while `enable_enc`=1. There is no backpressure.
- **Latency:** the last byte is sampled at edge k. The block and the `enc_valid` pulse are registered at the same edge k and are visible during cycle k+1.
- **Throughput:** one block every N cycles with back-to-back `enc_valid` pulses, N cycles apart.
- **Output hold:** outputs stay stable between `enc_valid` pulses.
- **`os_err` timing:** registered, one cycle after the offending byte.
- **`enable_enc` falling mid-block:** no `enc_valid` is produced. Re-enabling starts at byte 0 in the first enabled cycle.
- **`enable_enc` falling in the same cycle as byte N-1:** the byte is not captured and no block is emitted.
- **Reset mid-block:** immediate asynchronous clear of all state. The first enabled cycle after reset release is byte 0.

## Structure
- Shared package `usb4_enc_pkg` holds:
  - the speed codes `GEN4`/`GEN3`/`GEN2`;
  - header constants `HDR132_DATA`=4'b0101, `HDR132_OS`=4'b1010, `HDR66_DATA`=2'b01, `HDR66_OS`=2'b10.
  - The lane decoder imports the same package.
- One natural sub-module, `enc_lane_packer`:
  - one lane's 16-byte buffer plus header/zero-fill formatting;
  - instantiated twice.
- The counter, latches and `os_err` logic stay in the top level.

## Test plan
- **Gen3 data:** `data_os`=1, lane 0 bytes 0x00..0x0F, lane 1 bytes 0xF0..0xFF.
  - `enc_valid` pulses in the cycle after the 16th byte.
  - `lane_0_tx_enc` = {4'b0101, 0x0F0E…0100}; lane 1 uses the same header.
- **Gen2 ordered set:** `data_os`=0, bytes 0xA0..0xA7.
  - `lane_0_tx_enc[65:0]` = {2'b10, 0xA7A6…A0}; bits [131:66] = 0.
  - Pulses repeat every 8 cycles.
- **Gen4:** 32 consecutive bytes 0x00..0x1F.
  - Exactly two `enc_valid` pulses, 16 cycles apart.
  - Header bits are 0; the second block holds bytes 0x10..0x1F.
- **Abort:** `enable_enc` goes to 0 after 5 Gen3 bytes, then back to 1 with 16 new bytes.
  - A single `enc_valid` pulse occurs, and the block contains only the new bytes.
  - Outputs are unchanged during the abort.
- **Type glitch:** `data_os` flips 1→0 at Gen3 byte 7.
  - `os_err` pulses once, one cycle later.
  - The block header is still 4'b0101.
- **Mid-block changes:** a mid-block `gen_speed` change from Gen3 to Gen2 completes a 16-byte block before 8-byte blocks start. Asserting `rst` mid-block clears all outputs to 0 immediately.

Source files
------------

// File: rtl/usb4_enc_pkg.sv
// Shared USB4 block-coding constants: speed codes and sync headers.
// Imported by both the transmit encoder and the lane decoder.
package usb4_enc_pkg;

   localparam logic [1:0] GEN4 = 2'd0;
   localparam logic [1:0] GEN3 = 2'd1;
   localparam logic [1:0] GEN2 = 2'd2;

   localparam logic [3:0] HDR132_DATA = 4'b0101;
   localparam logic [3:0] HDR132_OS   = 4'b1010;
   localparam logic [1:0] HDR66_DATA  = 2'b01;
   localparam logic [1:0] HDR66_OS    = 2'b10;

   localparam int BLK_W = 132;

endpackage

// File: rtl/encoding_block_if.sv
// Byte-in / block-out bundle between lane adaptation, the encoder and the serializer.
// master drives bytes and controls; slave is the encoder producing blocks.
interface encoding_block_if;
   import usb4_enc_pkg::*;

   logic               enable_enc;
   logic [1:0]         gen_speed;
   logic               data_os;
   logic [7:0]         lane_0_tx;
   logic [7:0]         lane_1_tx;
   logic [BLK_W-1:0]   lane_0_tx_enc;
   logic [BLK_W-1:0]   lane_1_tx_enc;
   logic               enc_valid;
   logic               os_err;

   modport master (
      output enable_enc, gen_speed, data_os, lane_0_tx, lane_1_tx,
      input  lane_0_tx_enc, lane_1_tx_enc, enc_valid, os_err
   );

   modport slave (
      input  enable_enc, gen_speed, data_os, lane_0_tx, lane_1_tx,
      output lane_0_tx_enc, lane_1_tx_enc, enc_valid, os_err
   );

endinterface

// File: rtl/enc_lane_packer.sv
// One lane's 16-byte block buffer and header formatter; block registered on the last byte's edge.
// No backpressure: a byte is written on every cycle wr_en is high.
module enc_lane_packer #(
   parameter logic [1:0] GEN3 = usb4_enc_pkg::GEN3,
   parameter logic [1:0] GEN2 = usb4_enc_pkg::GEN2
) (
   input  logic                           enc_clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [3:0]                     wr_idx,
   input  logic [7:0]                     wr_byte,
   input  logic                           blk_done,
   input  logic [1:0]                     blk_gen,
   input  logic                           blk_data,
   output logic [usb4_enc_pkg::BLK_W-1:0] blk_out
);
   import usb4_enc_pkg::*;

   logic [15:0][7:0] buf_q;
   logic [15:0][7:0] buf_nxt;
   logic [BLK_W-1:0] blk_fmt;

   // The final byte is merged combinationally so the block loads on the same edge it arrives.
   always_comb begin
      buf_nxt = buf_q;
      if (wr_en)
         buf_nxt[wr_idx] = wr_byte;

      if (blk_gen == GEN2)
         blk_fmt = {66'd0, (blk_data ? HDR66_DATA : HDR66_OS), buf_nxt[7:0]};
      else if (blk_gen == GEN3)
         blk_fmt = {(blk_data ? HDR132_DATA : HDR132_OS), buf_nxt};
      else
         blk_fmt = {4'd0, buf_nxt};
   end

   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         buf_q   <= '0;
         blk_out <= '0;
      end else begin
         buf_q <= buf_nxt;
         if (blk_done)
            blk_out <= blk_fmt;
      end
   end

endmodule

// File: rtl/encoding_block.sv
// Two-lane USB4 transmit block encoder: enc_valid one cycle after the last byte of a block.
// No backpressure: one byte per lane is consumed every enabled enc_clk.
module encoding_block #(
   parameter logic [1:0] GEN4 = usb4_enc_pkg::GEN4,
   parameter logic [1:0] GEN3 = usb4_enc_pkg::GEN3,
   parameter logic [1:0] GEN2 = usb4_enc_pkg::GEN2
) (
   input  logic               enc_clk,
   input  logic               rst,
   encoding_block_if.slave    bus
);
   import usb4_enc_pkg::*;

   logic [3:0] byte_idx;
   logic [1:0] gen_q;
   logic       type_q;
   logic       enc_valid_q;
   logic       os_err_q;

   logic       first;
   logic [1:0] gen_eff;
   logic       type_eff;
   logic       reserved;
   logic [3:0] last_idx;
   logic       cap;
   logic       last;

   // At byte 0 the live speed/type define the block; afterwards the latched copies do.
   always_comb begin
      first    = (byte_idx == 4'd0);
      gen_eff  = first ? bus.gen_speed : gen_q;
      type_eff = first ? bus.data_os   : type_q;
      reserved = !((gen_eff == GEN2) || (gen_eff == GEN3) || (gen_eff == GEN4));
      last_idx = (gen_eff == GEN2) ? 4'd7 : 4'd15;
      cap      = bus.enable_enc && !reserved;
      last     = cap && (byte_idx == last_idx);
   end

   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         byte_idx    <= 4'd0;
         gen_q       <= 2'd0;
         type_q      <= 1'b0;
         enc_valid_q <= 1'b0;
         os_err_q    <= 1'b0;
      end else begin
         if (!cap || last)
            byte_idx <= 4'd0;
         else
            byte_idx <= byte_idx + 4'd1;

         if (cap && first) begin
            gen_q  <= bus.gen_speed;
            type_q <= bus.data_os;
         end

         enc_valid_q <= last;
         os_err_q    <= cap && !first && (bus.data_os != type_q);
      end
   end

   assign bus.enc_valid = enc_valid_q;
   assign bus.os_err    = os_err_q;

   enc_lane_packer #(.GEN3(GEN3), .GEN2(GEN2)) u_lane0 (
      .enc_clk  (enc_clk),
      .rst      (rst),
      .wr_en    (cap),
      .wr_idx   (byte_idx),
      .wr_byte  (bus.lane_0_tx),
      .blk_done (last),
      .blk_gen  (gen_eff),
      .blk_data (type_eff),
      .blk_out  (bus.lane_0_tx_enc)
   );

   enc_lane_packer #(.GEN3(GEN3), .GEN2(GEN2)) u_lane1 (
      .enc_clk  (enc_clk),
      .rst      (rst),
      .wr_en    (cap),
      .wr_idx   (byte_idx),
      .wr_byte  (bus.lane_1_tx),
      .blk_done (last),
      .blk_gen  (gen_eff),
      .blk_data (type_eff),
      .blk_out  (bus.lane_1_tx_enc)
   );

endmodule
